// File: rtl/rc_pkg.sv
// rtl/rc_pkg.sv - shared types and helpers for the relational cache row assembly path
package rc_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 4;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  // Bit offset of lane k inside a packed row of lanes that are size bits wide.
  function automatic int lane_slice(input int k, input int size = 16);
    return k * size;
  endfunction

endpackage

// File: rtl/row_out_reg.sv
// rtl/row_out_reg.sv - output row register with valid/ready hold for cache fill paths
module row_out_reg #(
  parameter int ROW_W  = 256,
  parameter int MASK_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [ROW_W-1:0]  row_in,
  input  logic [MASK_W-1:0] mask_in,
  input  logic              ready,
  output logic [ROW_W-1:0]  row,
  output logic [MASK_W-1:0] mask,
  output logic              valid,
  output logic              slot_free
);

  // The slot can take a new row when it is empty or its row leaves this cycle.
  assign slot_free = !valid | ready;

  // Load a new row (callers only load when slot_free), otherwise drop valid on acceptance
  // while holding row/mask stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row   <= '0;
      mask  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      row   <= row_in;
      mask  <= mask_in;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/row_assembler16.sv
// rtl/row_assembler16.sv - collects 16 demuxed column words into a row and hands it to cache fill
module row_assembler16
  import rc_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int AUTO_CLOSE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [SIZE-1:0]       i_lane_0,
  input  logic [SIZE-1:0]       i_lane_1,
  input  logic [SIZE-1:0]       i_lane_2,
  input  logic [SIZE-1:0]       i_lane_3,
  input  logic [SIZE-1:0]       i_lane_4,
  input  logic [SIZE-1:0]       i_lane_5,
  input  logic [SIZE-1:0]       i_lane_6,
  input  logic [SIZE-1:0]       i_lane_7,
  input  logic [SIZE-1:0]       i_lane_8,
  input  logic [SIZE-1:0]       i_lane_9,
  input  logic [SIZE-1:0]       i_lane_A,
  input  logic [SIZE-1:0]       i_lane_B,
  input  logic [SIZE-1:0]       i_lane_C,
  input  logic [SIZE-1:0]       i_lane_D,
  input  logic [SIZE-1:0]       i_lane_E,
  input  logic [SIZE-1:0]       i_lane_F,
  input  logic [LANE_W-1:0]     i_wr_sel,
  input  logic                  i_wr_en,
  input  logic                  i_last,
  input  logic                  i_flush,
  output logic                  o_wr_ready,
  output logic                  o_dup,
  output logic [LANES*SIZE-1:0] o_row,
  output logic [LANES-1:0]      o_mask,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [SIZE-1:0]       lane_in   [LANES];
  logic [SIZE-1:0]       asm_lane  [LANES];
  logic [SIZE-1:0]       next_lane [LANES];
  logic [SIZE-1:0]       sel_data;
  logic [LANES*SIZE-1:0] row_next;
  lane_mask_t            asm_mask;
  lane_mask_t            next_mask;
  lane_mask_t            sel_onehot;
  state_t                state;
  state_t                state_nxt;
  logic                  in_fill;
  logic                  wr_acc;
  logic                  close;
  logic                  load;
  logic                  clear;
  logic                  slot_free;
  logic                  dup;

  assign lane_in[0]  = i_lane_0;
  assign lane_in[1]  = i_lane_1;
  assign lane_in[2]  = i_lane_2;
  assign lane_in[3]  = i_lane_3;
  assign lane_in[4]  = i_lane_4;
  assign lane_in[5]  = i_lane_5;
  assign lane_in[6]  = i_lane_6;
  assign lane_in[7]  = i_lane_7;
  assign lane_in[8]  = i_lane_8;
  assign lane_in[9]  = i_lane_9;
  assign lane_in[10] = i_lane_A;
  assign lane_in[11] = i_lane_B;
  assign lane_in[12] = i_lane_C;
  assign lane_in[13] = i_lane_D;
  assign lane_in[14] = i_lane_E;
  assign lane_in[15] = i_lane_F;

  // Only the lane addressed by the demux select carries meaningful data.
  assign sel_data   = lane_in[i_wr_sel];
  assign sel_onehot = lane_mask_t'(1) << i_wr_sel;

  // Inputs are only honoured in FILL; in PEND the buffer is frozen awaiting the slot.
  assign in_fill   = (state == FILL);
  assign wr_acc    = i_wr_en & in_fill;
  assign next_mask = asm_mask | (wr_acc ? sel_onehot : '0);

  // A flush closes on the post-write mask, so flush+write closes even from an empty buffer.
  assign close = in_fill & ((wr_acc & i_last)
                          | ((AUTO_CLOSE != 0) & wr_acc & (next_mask == '1))
                          | (i_flush & (next_mask != '0)));

  // Lane capture: the transferred row always includes a write landing in the same cycle.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign next_lane[k] = (wr_acc && (i_wr_sel == LANE_W'(k))) ? sel_data : asm_lane[k];
    assign row_next[lane_slice(k, SIZE) +: SIZE] = next_lane[k];

    // Hold or update one lane of the assembly buffer; cleared when its row moves out.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        asm_lane[k] <= '0;
      end else if (clear) begin
        asm_lane[k] <= '0;
      end else begin
        asm_lane[k] <= next_lane[k];
      end
    end
  end

  // Filled-lane mask of the assembly buffer.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      asm_mask <= '0;
    end else if (clear) begin
      asm_mask <= '0;
    end else begin
      asm_mask <= next_mask;
    end
  end

  // Duplicate-lane flag, a single-cycle pulse after the offending write.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dup <= 1'b0;
    end else begin
      dup <= wr_acc & |(asm_mask & sel_onehot);
    end
  end

  assign o_dup = dup;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and transfer control: move a closed row out as soon as the slot frees.
  always_comb begin
    state_nxt  = state;
    o_wr_ready = 1'b0;
    load       = 1'b0;
    clear      = 1'b0;
    case (state)
      FILL: begin
        o_wr_ready = 1'b1;
        if (close) begin
          if (slot_free) begin
            load  = 1'b1;
            clear = 1'b1;
          end else begin
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (slot_free) begin
          load      = 1'b1;
          clear     = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  row_out_reg #(
    .ROW_W (LANES*SIZE),
    .MASK_W(LANES)
  ) u_out (
    .clk      (i_clk),
    .rstn     (i_rstn),
    .load     (load),
    .row_in   (row_next),
    .mask_in  (next_mask),
    .ready    (i_ready),
    .row      (o_row),
    .mask     (o_mask),
    .valid    (o_valid),
    .slot_free(slot_free)
  );

endmodule

// File: tb/tb_row_assembler16.sv
// tb/tb_row_assembler16.sv - directed vector bench for row_assembler16
module tb_row_assembler16;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic [15:0]  lanes [16];
  logic [3:0]   i_wr_sel;
  logic         i_wr_en, i_last, i_flush, i_ready;
  logic         o_wr_ready, o_dup, o_valid;
  logic [255:0] o_row;
  logic [15:0]  o_mask;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  row_assembler16 #(.SIZE(16), .AUTO_CLOSE(1)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_lane_0(lanes[0]),  .i_lane_1(lanes[1]),  .i_lane_2(lanes[2]),  .i_lane_3(lanes[3]),
    .i_lane_4(lanes[4]),  .i_lane_5(lanes[5]),  .i_lane_6(lanes[6]),  .i_lane_7(lanes[7]),
    .i_lane_8(lanes[8]),  .i_lane_9(lanes[9]),  .i_lane_A(lanes[10]), .i_lane_B(lanes[11]),
    .i_lane_C(lanes[12]), .i_lane_D(lanes[13]), .i_lane_E(lanes[14]), .i_lane_F(lanes[15]),
    .i_wr_sel(i_wr_sel), .i_wr_en(i_wr_en), .i_last(i_last), .i_flush(i_flush),
    .o_wr_ready(o_wr_ready), .o_dup(o_dup), .o_row(o_row), .o_mask(o_mask),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  typedef struct {
    logic        en;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        last;
    logic        flush;
    logic        rdy;
    logic        ev;
    logic        ewr;
    logic        edup;
    logic [15:0] emask;
    int          ka;
    logic [15:0] va;
    int          kb;
    logic [15:0] vb;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-selected lanes carry junk so that lane isolation is exercised.
  task automatic drive(input logic en, input logic [3:0] sel, input logic [15:0] data,
                       input logic last, input logic flush, input logic rdy);
    for (int k = 0; k < 16; k++) lanes[k] = 16'hF0F0 ^ 16'(k * 16'h0111);
    lanes[sel] = data;
    i_wr_en  = en;
    i_wr_sel = sel;
    i_last   = last;
    i_flush  = flush;
    i_ready  = rdy;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] lane_of(input logic [255:0] row, input int k);
    return row[k*16 +: 16];
  endfunction

  initial begin
    vecs[0] = '{1'b1, 4'd2, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0, 0, 16'h0};
    vecs[1] = '{1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0024, 2, 16'hAAAA, 5, 16'h5555};
    vecs[2] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0, 0, 16'h0};
    vecs[3] = '{1'b1, 4'd3, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0, 0, 16'h0};
    vecs[4] = '{1'b1, 4'd3, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 16'h0, 0, 16'h0};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0008, 3, 16'h2222, 2, 16'h0000};
    vecs[6] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0, 0, 16'h0};
    vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0, 0, 16'h0};

    i_rstn = 1'b0;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(); step();
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_mask", 32'(o_mask), 32'd0);
    chk("reset_row_zero", 32'(|o_row), 32'd0);
    chk("reset_wr_ready", 32'(o_wr_ready), 32'd1);
    chk("reset_dup", 32'(o_dup), 32'd0);
    i_rstn = 1'b1;
    step();

    // Partial row, duplicate write, flush and empty flush.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].en, vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].flush, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_wr_ready", i), 32'(o_wr_ready), 32'(vecs[i].ewr));
      chk($sformatf("vec%0d_dup", i), 32'(o_dup), 32'(vecs[i].edup));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_mask", i), 32'(o_mask), 32'(vecs[i].emask));
        chk($sformatf("vec%0d_lane%0d", i, vecs[i].ka), 32'(lane_of(o_row, vecs[i].ka)), 32'(vecs[i].va));
        chk($sformatf("vec%0d_lane%0d", i, vecs[i].kb), 32'(lane_of(o_row, vecs[i].kb)), 32'(vecs[i].vb));
      end
    end

    // Sequential fill closes automatically on the last lane.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'(k), 16'h1000 + 16'(k), 1'b0, 1'b0, 1'b1);
      step();
      chk($sformatf("seq_wr_ready_%0d", k), 32'(o_wr_ready), 32'd1);
      chk($sformatf("seq_valid_%0d", k), 32'(o_valid), (k == 15) ? 32'd1 : 32'd0);
    end
    chk("seq_mask", 32'(o_mask), 32'h0000FFFF);
    for (int k = 0; k < 16; k++)
      chk($sformatf("seq_lane%0d", k), 32'(lane_of(o_row, k)), 32'h1000 + 32'(k));
    drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    step();
    chk("seq_drained", 32'(o_valid), 32'd0);

    // Backpressure: row A held, row B parked in PEND.
    drive(1'b1, 4'd0, 16'h000A, 1'b1, 1'b0, 1'b0);
    step();
    chk("bp_a_valid", 32'(o_valid), 32'd1);
    chk("bp_a_mask", 32'(o_mask), 32'h1);
    drive(1'b1, 4'd1, 16'h000B, 1'b1, 1'b0, 1'b0);
    step();
    chk("bp_pend_wr_ready", 32'(o_wr_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 4'd2, 16'h000C, 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("bp_hold_valid_%0d", c), 32'(o_valid), 32'd1);
      chk($sformatf("bp_hold_mask_%0d", c), 32'(o_mask), 32'h1);
      chk($sformatf("bp_hold_lane0_%0d", c), 32'(lane_of(o_row, 0)), 32'hA);
      chk($sformatf("bp_hold_wr_ready_%0d", c), 32'(o_wr_ready), 32'd0);
    end
    drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    step();
    chk("bp_b_valid", 32'(o_valid), 32'd1);
    chk("bp_b_mask", 32'(o_mask), 32'h2);
    chk("bp_b_lane1", 32'(lane_of(o_row, 1)), 32'hB);
    chk("bp_b_lane0", 32'(lane_of(o_row, 0)), 32'h0);
    chk("bp_b_wr_ready", 32'(o_wr_ready), 32'd1);
    step();
    chk("bp_b_drained", 32'(o_valid), 32'd0);

    // Reset while PEND with a row on the output.
    drive(1'b1, 4'd0, 16'h0101, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd1, 16'h0202, 1'b1, 1'b0, 1'b0);
    step();
    chk("rst_pre_wr_ready", 32'(o_wr_ready), 32'd0);
    chk("rst_pre_valid", 32'(o_valid), 32'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("rst_async_valid", 32'(o_valid), 32'd0);
    chk("rst_async_mask", 32'(o_mask), 32'd0);
    chk("rst_async_wr_ready", 32'(o_wr_ready), 32'd1);
    drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    step();
    i_rstn = 1'b1;
    step();
    chk("rst_post_valid", 32'(o_valid), 32'd0);
    drive(1'b1, 4'd7, 16'h7777, 1'b1, 1'b0, 1'b1);
    step();
    chk("rst_l7_valid", 32'(o_valid), 32'd1);
    chk("rst_l7_mask", 32'(o_mask), 32'h0080);
    chk("rst_l7_lane7", 32'(lane_of(o_row, 7)), 32'h7777);
    chk("rst_l7_lane1", 32'(lane_of(o_row, 1)), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
